ifu_fetch_ctrl: RTL and testbench

//   Multi-cycle instruction fetch controller. It sits between the PC-update path (EXU next-PC)
//   and the IDU, and replaces the combinational fetch.
//   - Holds the fetch PC and issues one read at a time to the instruction memory over a

---
 rtl/ifu_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - multi-cycle instruction fetch controller
// One outstanding imem read at a time; faults are delivered to the IDU as zeroed instructions.
module ifu_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  input  logic              imem_resp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              pc_upd_valid,
  input  logic [ADDR_W-1:0] pc_upd
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, EXEC} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [31:0]        inst_q;
  logic               fault_q;
  logic               drop_pending;
  logic [CNT_W-1:0]   tmo_cnt;

  logic misaligned, req_hs, resp_take, timeout, pc_load;

  assign misaligned = |pc[1:0];
  assign req_hs     = (state == REQ) && !misaligned && imem_req_ready;
  // A response while a stale one is owed is the stale one, so it never reaches the IDU.
  assign resp_take  = (state == WAIT) && imem_resp_valid && !drop_pending;
  assign timeout    = (state == WAIT) && !resp_take && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign pc_load    = pc_upd_valid && (((state == OUT) && inst_ready) || (state == EXEC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inst_q       <= '0;
      fault_q      <= 1'b0;
      drop_pending <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load) pc <= pc_upd;
      if ((state == REQ) && misaligned) begin
        inst_q  <= '0;
        fault_q <= 1'b1;
      end else if (resp_take) begin
        inst_q  <= imem_resp_err ? 32'h0 : imem_resp_data;
        fault_q <= imem_resp_err;
      end else if (timeout) begin
        inst_q  <= '0;
        fault_q <= 1'b1;
      end
      if (req_hs) tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
      // The abandoned request still owes one response; set wins over a same-cycle drop.
      if (timeout) drop_pending <= 1'b1;
      else if (imem_resp_valid) drop_pending <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (misaligned) state_nxt = OUT;
        else if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: if (resp_take || timeout) state_nxt = OUT;
      OUT: begin
        if (inst_ready) state_nxt = pc_upd_valid ? REQ : EXEC;
      end
      EXEC: if (pc_upd_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ) && !misaligned;
    imem_req_addr  = pc;
    inst_valid     = (state == OUT);
    inst           = inst_q;
    inst_fault     = fault_q;
    inst_pc        = pc;
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb/tb_ifu_fetch_ctrl.sv - directed self-checking bench for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;

  int vectors = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h80000000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault),
    .pc_upd_valid(pc_upd_valid), .pc_upd(pc_upd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_inst,
                         input logic e_fault, input logic [31:0] e_pc);
    chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    chk({tag, "_inst"},  inst, e_inst);
    chk({tag, "_fault"}, {31'b0, inst_fault}, {31'b0, e_fault});
    chk({tag, "_pc"},    inst_pc, e_pc);
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    inst_ready = 1'b0; pc_upd_valid = 1'b0; pc_upd = '0;
    tick(); tick();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_addr", imem_req_addr, 32'h80000000);
    chk("rst_inst_pc", inst_pc, 32'h80000000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_fault", {31'b0, inst_fault}, 32'd0);

    // 1: first fetch, ready memory, 1-cycle response
    rst = 1'b1;
    tick();
    chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t1_addr", imem_req_addr, 32'h80000000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t1_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
    chk("t1_wait_noinst", {31'b0, inst_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00000413;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t1", 32'h00000413, 1'b0, 32'h80000000);

    // 3: consume and redirect in the same cycle
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h80000004;
    tick();
    inst_ready = 1'b0; pc_upd_valid = 1'b0;
    chk("t3_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t3_addr", imem_req_addr, 32'h80000004);

    // 2: memory stalls the request for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_req_held", {31'b0, imem_req_valid}, 32'd1);
      chk("t2_addr_held", imem_req_addr, 32'h80000004);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t2_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h00100093;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t2", 32'h00100093, 1'b0, 32'h80000004);

    // consume without redirect -> EXEC, then misaligned redirect
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("exec_noinst", {31'b0, inst_valid}, 32'd0);
    chk("exec_noreq", {31'b0, imem_req_valid}, 32'd0);
    pc_upd_valid = 1'b1; pc_upd = 32'h80000002;
    tick();
    pc_upd_valid = 1'b0;
    chk("t4_noreq", {31'b0, imem_req_valid}, 32'd0);
    tick();
    chk("t4_noreq2", {31'b0, imem_req_valid}, 32'd0);
    chk_out("t4", 32'h0, 1'b1, 32'h80000002);

    // 5: timeout, then the late response is dropped
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h80000008;
    tick();
    inst_ready = 1'b0; pc_upd_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n = 0;
    while (!inst_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t5_tmo_cycles", n, 32'd16);
    chk_out("t5_tmo", 32'h0, 1'b1, 32'h80000008);
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h8000000C;
    tick();
    inst_ready = 1'b0; pc_upd_valid = 1'b0;
    chk("t5_req_addr", imem_req_addr, 32'h8000000C);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEADBEEF;
    tick();
    chk("t5_dropped", {31'b0, inst_valid}, 32'd0);
    imem_resp_data = 32'h00200113;
    tick();
    imem_resp_valid = 1'b0;
    chk_out("t5", 32'h00200113, 1'b0, 32'h8000000C);

    // 6: memory error, then reset in WAIT
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h80000010;
    tick();
    inst_ready = 1'b0; pc_upd_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_err = 1'b1; imem_resp_data = 32'h12345678;
    tick();
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    chk_out("t6_err", 32'h0, 1'b1, 32'h80000010);
    inst_ready = 1'b1; pc_upd_valid = 1'b1; pc_upd = 32'h80000014;
    tick();
    inst_ready = 1'b0; pc_upd_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_rst_fault", {31'b0, inst_fault}, 32'd0);
    chk("t6_rst_addr", imem_req_addr, 32'h80000000);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_refetch_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t6_refetch_addr", imem_req_addr, 32'h80000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
